// File: rtl/mips_rf_pkg.sv
// Shared constants and helpers for the pipelined MIPS multi-port register file.
package mips_rf_pkg;

    localparam int unsigned DEF_REG_WIDTH  = 32;
    localparam int unsigned DEF_REG_DEPTH  = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    // Widest busy vector popcount() accepts; deeper files must raise this.
    localparam int unsigned MAX_REG_DEPTH  = 64;
    localparam int unsigned ZERO_ADDR      = 0;

    function automatic int unsigned popcount(input logic [MAX_REG_DEPTH-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < int'(MAX_REG_DEPTH); i++) begin
            cnt = cnt + {31'b0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-side bus of the multi-port register file.
interface reg_file_mp_if #(
    parameter int unsigned REG_WIDTH  = mips_rf_pkg::DEF_REG_WIDTH,
    parameter int unsigned ADDR_WIDTH = mips_rf_pkg::DEF_ADDR_WIDTH,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 1
);

    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*REG_WIDTH-1:0]  rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*REG_WIDTH-1:0]  wr_data;
    logic                         issue_en;
    logic [ADDR_WIDTH-1:0]        issue_addr;
    logic [ADDR_WIDTH:0]          busy_count;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data, rd_busy, busy_count
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data, rd_busy, busy_count
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, plus a registered busy count.
module rf_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int unsigned REG_DEPTH  = DEF_REG_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_WR     = 1,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic                         issue_en_i,
    input  logic [ADDR_WIDTH-1:0]        issue_addr_i,
    output logic [REG_DEPTH-1:0]         busy_o,
    output logic [ADDR_WIDTH:0]          busy_count_o
);

    logic [REG_DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_WIDTH:0]   busy_count_q, busy_count_d;

    // Clears first, then the issue: a new producer outranks a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < int'(NUM_WR); j++) begin
            if (wr_en_i[j]) begin
                busy_d[wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (issue_en_i) begin
            busy_d[issue_addr_i] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[ZERO_ADDR] = 1'b0;
        end
        busy_count_d = (ADDR_WIDTH+1)'(popcount(MAX_REG_DEPTH'(busy_d)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = busy_count_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass, optional zero register and busy scoreboard.
module reg_file_mp
    import mips_rf_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
    parameter int unsigned REG_DEPTH  = DEF_REG_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 1,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    reg_file_mp_if.slave   bus_io
);

    logic [REG_WIDTH-1:0]        regs_q [REG_DEPTH];
    logic [REG_WIDTH-1:0]        regs_d [REG_DEPTH];
    logic [REG_DEPTH-1:0]        busy;
    logic [NUM_RD*REG_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]           rd_busy;

    // Port order gives the collision rule: the highest-index port is applied last.
    always_comb begin
        logic [ADDR_WIDTH-1:0] waddr;
        waddr  = '0;
        regs_d = regs_q;
        for (int j = 0; j < int'(NUM_WR); j++) begin
            waddr = bus_io.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            if (bus_io.wr_en[j] && !(ZERO_REG && (32'(waddr) == ZERO_ADDR))) begin
                regs_d[waddr] = bus_io.wr_data[j*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(REG_DEPTH); k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(REG_DEPTH); k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] raddr;
        logic [REG_WIDTH-1:0]  rdata;
        logic                  hit;
        raddr   = '0;
        rdata   = '0;
        hit     = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            raddr = bus_io.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rdata = regs_q[raddr];
            hit   = 1'b0;
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (bus_io.wr_en[j] && (bus_io.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == raddr)) begin
                    rdata = bus_io.wr_data[j*REG_WIDTH +: REG_WIDTH];
                    hit   = 1'b1;
                end
            end
            // Bypass data must not leak out while reset holds the array at zero.
            if (!reset || (ZERO_REG && (32'(raddr) == ZERO_ADDR))) begin
                rd_data[i*REG_WIDTH +: REG_WIDTH] = '0;
                rd_busy[i]                        = 1'b0;
            end else begin
                rd_data[i*REG_WIDTH +: REG_WIDTH] = rdata;
                rd_busy[i]                        = busy[raddr] & ~hit;
            end
        end
    end

    assign bus_io.rd_data = rd_data;
    assign bus_io.rd_busy = rd_busy;

    rf_scoreboard #(
        .REG_DEPTH  (REG_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WR     (NUM_WR),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk_i        (clk),
        .rst_ni       (reset),
        .wr_en_i      (bus_io.wr_en),
        .wr_addr_i    (bus_io.wr_addr),
        .issue_en_i   (bus_io.issue_en),
        .issue_addr_i (bus_io.issue_addr),
        .busy_o       (busy),
        .busy_count_o (bus_io.busy_count)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: dut_a uses defaults (zero reg, one write port), dut_b has no zero reg, two write ports.
module tb_reg_file_mp;

    logic clk;
    logic reset;

    int unsigned n_checks;
    int unsigned n_fails;

    reg_file_mp_if ifa ();
    reg_file_mp_if #(.NUM_WR(2)) ifb ();

    reg_file_mp dut_a (
        .clk    (clk),
        .reset  (reset),
        .bus_io (ifa)
    );

    reg_file_mp #(
        .NUM_WR   (2),
        .ZERO_REG (1'b0)
    ) dut_b (
        .clk    (clk),
        .reset  (reset),
        .bus_io (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] acc;
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        ifa.rd_addr = '0; ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
        ifa.issue_en = 1'b0; ifa.issue_addr = '0;
        ifb.rd_addr = '0; ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
        ifb.issue_en = 1'b0; ifb.issue_addr = '0;

        // Held in reset with a write pending: nothing stored, nothing bypassed.
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd5; ifa.wr_data = 32'hDEADBEEF;
        ifa.rd_addr = {5'd5, 5'd5};
        #12;
        check_eq("rst_hold_rd", ifa.rd_data[31:0], 32'h0);
        check_eq("rst_hold_bc", 32'(ifa.busy_count), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("byp_rel_rd", ifa.rd_data[63:32], 32'hDEADBEEF);
        tick();
        ifa.wr_en = 1'b0;
        #1;
        check_eq("wr5_rd", ifa.rd_data[31:0], 32'hDEADBEEF);
        ifa.issue_en = 1'b1; ifa.issue_addr = 5'd6;
        tick();
        ifa.issue_en = 1'b0;
        check_eq("iss6_bc", 32'(ifa.busy_count), 32'd1);

        // Asynchronous reset mid-write and mid-issue.
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd5; ifa.wr_data = 32'h00000001;
        ifa.issue_en = 1'b1; ifa.issue_addr = 5'd8;
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_async_bc", 32'(ifa.busy_count), 32'd0);
        check_eq("rst_async_rd", ifa.rd_data[31:0], 32'h0);
        ifa.wr_en = 1'b0; ifa.issue_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        acc = '0;
        for (int a = 0; a < 32; a++) begin
            ifa.rd_addr = {5'(a), 5'(a)};
            #1;
            acc = acc | ifa.rd_data[31:0] | ifa.rd_data[63:32] | 32'(ifa.rd_busy);
        end
        check_eq("rst_all_rd", acc, 32'h0);
        check_eq("rst_rel_bc", 32'(ifa.busy_count), 32'd0);

        // Write then read with bypass.
        tick();
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd7; ifa.wr_data = 32'h12345678;
        ifa.rd_addr = {5'd7, 5'd7};
        #1;
        check_eq("byp7_p0", ifa.rd_data[31:0], 32'h12345678);
        check_eq("byp7_p1", ifa.rd_data[63:32], 32'h12345678);
        tick();
        ifa.wr_en = 1'b0;
        #1;
        check_eq("st7_p0", ifa.rd_data[31:0], 32'h12345678);

        // Zero register on dut_a; plain register 0 on dut_b.
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd0; ifa.wr_data = 32'hFFFFFFFF;
        ifa.rd_addr = {5'd7, 5'd0};
        ifb.wr_en = 2'b01; ifb.wr_addr = {5'd0, 5'd0}; ifb.wr_data = {32'h0, 32'hFFFFFFFF};
        ifb.rd_addr = {5'd0, 5'd0};
        #1;
        check_eq("zero_byp", ifa.rd_data[31:0], 32'h0);
        check_eq("nz_byp", ifb.rd_data[31:0], 32'hFFFFFFFF);
        tick();
        ifa.wr_en = 1'b0; ifb.wr_en = 2'b00;
        ifa.issue_en = 1'b1; ifa.issue_addr = 5'd0;
        ifb.issue_en = 1'b1; ifb.issue_addr = 5'd0;
        #1;
        check_eq("zero_st", ifa.rd_data[31:0], 32'h0);
        check_eq("nz_st", ifb.rd_data[31:0], 32'hFFFFFFFF);
        tick();
        ifa.issue_en = 1'b0; ifb.issue_en = 1'b0;
        #1;
        check_eq("zero_iss_bc", 32'(ifa.busy_count), 32'd0);
        check_eq("zero_iss_busy", 32'(ifa.rd_busy[0]), 32'd0);
        check_eq("nz_iss_bc", 32'(ifb.busy_count), 32'd1);
        check_eq("nz_iss_busy", 32'(ifb.rd_busy[0]), 32'd1);

        // Scoreboard: issue 3, 4, 9.
        ifa.issue_en = 1'b1; ifa.issue_addr = 5'd3;
        tick();
        check_eq("sb_bc1", 32'(ifa.busy_count), 32'd1);
        ifa.issue_addr = 5'd4;
        tick();
        check_eq("sb_bc2", 32'(ifa.busy_count), 32'd2);
        ifa.issue_addr = 5'd9;
        tick();
        ifa.issue_en = 1'b0;
        ifa.rd_addr = {5'd4, 5'd3};
        #1;
        check_eq("sb_bc3", 32'(ifa.busy_count), 32'd3);
        check_eq("sb_busy4", 32'(ifa.rd_busy[1]), 32'd1);
        check_eq("sb_busy3", 32'(ifa.rd_busy[0]), 32'd1);
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd4; ifa.wr_data = 32'h00000044;
        #1;
        check_eq("wb4_busy_byp", 32'(ifa.rd_busy[1]), 32'd0);
        check_eq("wb4_data_byp", ifa.rd_data[63:32], 32'h00000044);
        tick();
        ifa.wr_en = 1'b0;
        ifa.rd_addr = {5'd4, 5'd9};
        #1;
        check_eq("wb4_bc", 32'(ifa.busy_count), 32'd2);
        check_eq("wb4_busy", 32'(ifa.rd_busy[1]), 32'd0);
        check_eq("busy9", 32'(ifa.rd_busy[0]), 32'd1);

        // Issue only shows on rd_busy a cycle later.
        ifa.issue_en = 1'b1; ifa.issue_addr = 5'd11;
        ifa.rd_addr = {5'd4, 5'd11};
        #1;
        check_eq("iss11_same", 32'(ifa.rd_busy[0]), 32'd0);
        tick();
        ifa.issue_en = 1'b0;
        check_eq("iss11_next", 32'(ifa.rd_busy[0]), 32'd1);
        check_eq("iss11_bc", 32'(ifa.busy_count), 32'd3);

        // Issue 10, then issue and write 10 together: busy stays, count unchanged.
        ifa.issue_en = 1'b1; ifa.issue_addr = 5'd10;
        tick();
        check_eq("iss10_bc", 32'(ifa.busy_count), 32'd4);
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd10; ifa.wr_data = 32'hCAFEF00D;
        ifa.rd_addr = {5'd4, 5'd10};
        #1;
        check_eq("pair10_busy_byp", 32'(ifa.rd_busy[0]), 32'd0);
        tick();
        ifa.issue_en = 1'b0; ifa.wr_en = 1'b0;
        #1;
        check_eq("pair10_bc", 32'(ifa.busy_count), 32'd4);
        check_eq("pair10_busy", 32'(ifa.rd_busy[0]), 32'd1);
        check_eq("pair10_data", ifa.rd_data[31:0], 32'hCAFEF00D);

        // Two-port collision on dut_b: port 1 wins.
        ifb.wr_en = 2'b11; ifb.wr_addr = {5'd12, 5'd12};
        ifb.wr_data = {32'h5555FFFF, 32'hAAAA0000};
        ifb.rd_addr = {5'd12, 5'd12};
        #1;
        check_eq("coll_byp", ifb.rd_data[31:0], 32'h5555FFFF);
        tick();
        ifb.wr_en = 2'b10; ifb.wr_addr = {5'd13, 5'd12}; ifb.wr_data = {32'h13131313, 32'h0};
        ifb.rd_addr = {5'd13, 5'd12};
        #1;
        check_eq("coll_st", ifb.rd_data[31:0], 32'h5555FFFF);
        check_eq("p1_byp", ifb.rd_data[63:32], 32'h13131313);
        tick();
        ifb.wr_en = 2'b00;
        #1;
        check_eq("p1_st", ifb.rd_data[63:32], 32'h13131313);
        check_eq("p1_no_p0", ifb.rd_data[31:0], 32'h5555FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
